// File: rtl/fetch_pair_queue_pkg.sv
// fetch_pair_queue_pkg: instruction field layout shared by the fetch queue and the relayer
package fetch_pair_queue_pkg;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP = '0;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int IMM_BIT = 11;
  localparam int DST_MSB = 10;
  localparam int DST_LSB = 8;
  localparam int SRC1_MSB = 7;
  localparam int SRC1_LSB = 5;
  localparam int SRC2_MSB = 4;
  localparam int SRC2_LSB = 2;
endpackage

// File: rtl/fetch_pair_queue_if.sv
// fetch_pair_queue_if: I-memory, issue-pair and redirect signals of the fetch queue
interface fetch_pair_queue_if import fetch_pair_queue_pkg::*; #(parameter int DEPTH = 8, parameter int PC_W = 16) ();
  localparam int CW = $clog2(DEPTH) + 1;
  logic imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [2*INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr1_o;
  logic [INSTR_W-1:0] instr2_o;
  logic pair_valid;
  logic [1:0] issue_cnt;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [CW-1:0] count_o;
  logic err_o;
  modport master (
    output imem_rd_en, imem_addr, instr1_o, instr2_o, pair_valid, count_o, err_o,
    input imem_rdata, issue_cnt, redirect, redirect_pc
  );
  modport slave (
    input imem_rd_en, imem_addr, instr1_o, instr2_o, pair_valid, count_o, err_o,
    output imem_rdata, issue_cnt, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fifo_2w2r.sv
// instr_fifo_2w2r: circular instruction buffer with 2-wide push, 0..2 pop and flush
module instr_fifo_2w2r import fetch_pair_queue_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic [2*INSTR_W-1:0] wdata,
  input  logic [1:0] pop,
  output logic [INSTR_W-1:0] rd0,
  output logic [INSTR_W-1:0] rd1,
  output logic [CW-1:0] count
);
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(2) : wr_ptr;
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + (push ? CW'(2) : CW'(0)) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= wdata[INSTR_W-1:0];
      mem[wr_ptr + PW'(1)] <= wdata[2*INSTR_W-1:INSTR_W];
    end
  end
  assign rd0 = (count == '0) ? NOP : mem[rd_ptr];
  assign rd1 = (count < CW'(2)) ? NOP : mem[rd_ptr + PW'(1)];
endmodule

// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: fetches instruction pairs from I-memory and presents the two oldest to the relayer
module fetch_pair_queue import fetch_pair_queue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int PC_W = 16
) (
  input logic clk,
  input logic rst,
  fetch_pair_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = CW + 1;
  logic [PC_W-1:0] pc;
  logic inflight, err, req, push;
  logic [CW-1:0] count;
  logic [1:0] pop;
  // Credit the outstanding response but not this cycle's pops, so the buffer can never overflow
  assign req = !rst && !bus.redirect && (NW'(count) + (inflight ? NW'(4) : NW'(2)) <= NW'(DEPTH));
  assign push = inflight && !bus.redirect;
  assign pop = (bus.redirect || &bus.issue_cnt) ? 2'd0 : (CW'(bus.issue_cnt) > count) ? count[1:0] : bus.issue_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      inflight <= 1'b0;
      err <= 1'b0;
    end else begin
      inflight <= req;
      pc <= bus.redirect ? bus.redirect_pc : req ? pc + PC_W'(2) : pc;
      err <= err || (!bus.redirect && &bus.issue_cnt);
    end
  end
  instr_fifo_2w2r #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(bus.redirect),
    .push(push),
    .wdata(bus.imem_rdata),
    .pop(pop),
    .rd0(bus.instr1_o),
    .rd1(bus.instr2_o),
    .count(count)
  );
  assign bus.imem_rd_en = req;
  assign bus.imem_addr = pc;
  assign bus.count_o = count;
  assign bus.pair_valid = count >= CW'(2);
  assign bus.err_o = err;
endmodule

// File: tb/tb_fetch_pair_queue.sv
// tb_fetch_pair_queue: scoreboard bench comparing the fetch queue against a queue-based reference
module tb_fetch_pair_queue;
  import fetch_pair_queue_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [15:0] m_q[$];
  logic [15:0] m_pc, m_pend0, m_pend1;
  logic m_infl, m_err;
  fetch_pair_queue_if #(.DEPTH(8), .PC_W(16)) bus ();
  fetch_pair_queue #(.DEPTH(8), .PC_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'h1000 | a;
  endfunction
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_rd_en ? {memf(bus.imem_addr + 16'd1), memf(bus.imem_addr)} : 32'h0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic step(input logic [1:0] ic, input logic rd, input logic [15:0] rpc);
    logic req;
    int p;
    @(negedge clk);
    bus.issue_cnt = ic;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    #1;
    req = !rd && (m_q.size() + (m_infl ? 2 : 0) + 2 <= 8);
    chk("rd_en", bus.imem_rd_en, req);
    if (req) chk("addr", bus.imem_addr, m_pc);
    chk("instr1", bus.instr1_o, m_q.size() > 0 ? m_q[0] : NOP);
    chk("instr2", bus.instr2_o, m_q.size() > 1 ? m_q[1] : NOP);
    chk("pair_valid", bus.pair_valid, m_q.size() >= 2);
    chk("count", bus.count_o, m_q.size());
    chk("err", bus.err_o, m_err);
    if (rd) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc = rpc;
    end else begin
      p = (ic == 2'd3) ? 0 : (int'(ic) > m_q.size() ? m_q.size() : int'(ic));
      repeat (p) void'(m_q.pop_front());
      if (m_infl) begin
        m_q.push_back(m_pend0);
        m_q.push_back(m_pend1);
      end
      if (req) begin
        m_pend0 = memf(m_pc);
        m_pend1 = memf(m_pc + 16'd1);
        m_pc = m_pc + 16'd2;
      end
      m_infl = req;
      if (ic == 2'd3) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.issue_cnt = 2'd0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    m_pc = 16'h0;
    m_infl = 1'b0;
    m_err = 1'b0;
    m_pend0 = 16'h0;
    m_pend1 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", bus.imem_rd_en, 1'b0);
    chk("rst_count", bus.count_o, 4'd0);
    chk("rst_instr1", bus.instr1_o, NOP);
    chk("rst_pair_valid", bus.pair_valid, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    rst = 1'b0;
    repeat (6) step(2'd0, 1'b0, 16'h0);
    chk("fill_count", bus.count_o, 4'd8);
    chk("fill_addr", bus.imem_addr, 16'h0008);
    chk("fill_instr1", bus.instr1_o, 16'h1000);
    chk("fill_instr2", bus.instr2_o, 16'h1001);
    step(2'd2, 1'b0, 16'h0);
    step(2'd2, 1'b0, 16'h0);
    chk("dual_instr1", bus.instr1_o, 16'h1004);
    chk("dual_instr2", bus.instr2_o, 16'h1005);
    step(2'd1, 1'b0, 16'h0);
    chk("single_instr1", bus.instr1_o, 16'h1005);
    chk("single_instr2", bus.instr2_o, 16'h1006);
    repeat (10) step(2'd2, 1'b0, 16'h0);
    for (int i = 0; i < 8 && !m_infl; i++) step(2'd2, 1'b0, 16'h0);
    step(2'd2, 1'b1, 16'h0040);
    chk("redir_count", bus.count_o, 4'd0);
    chk("redir_addr", bus.imem_addr, 16'h0040);
    step(2'd2, 1'b0, 16'h0);
    chk("under_count", bus.count_o, 4'd0);
    chk("under_instr2", bus.instr2_o, NOP);
    chk("under_pair_valid", bus.pair_valid, 1'b0);
    step(2'd0, 1'b0, 16'h0);
    chk("redir_instr1", bus.instr1_o, 16'h1040);
    chk("redir_instr2", bus.instr2_o, 16'h1041);
    step(2'd0, 1'b1, 16'hFFFE);
    step(2'd0, 1'b0, 16'h0);
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    repeat (3) step(2'd1, 1'b0, 16'h0);
    step(2'd3, 1'b0, 16'h0);
    chk("illegal_err", bus.err_o, 1'b1);
    for (int i = 0; i < 150; i++)
      step(2'($urandom_range(0, 2)), $urandom_range(0, 15) == 0, 16'($urandom));
    chk("err_sticky", bus.err_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rerst_err", bus.err_o, 1'b0);
    chk("rerst_count", bus.count_o, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
